// File: rtl/tablero_gato.sv
// tablero_gato: board-state writer for tic-tac-toe (gato).
// Accepts moves over a valid/ready handshake and rejects out-of-range or
// occupied cells. It writes the nine 2-bit cells, toggles verifica_status
// once per accepted move, samples the verifier verdict VERIF_WAIT cycles
// later, and then either passes the turn or enters FIN.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   move_valid/move_pos move request and target cell 1..9
//   move_ready          block accepts a move this cycle
//   new_game            sync pulse: clear board, count and turn
//   game_over           OR of the verifier's win/tie outputs
//   reg_c1..reg_c9      cell state: 00 empty, 11 player 1, 01 player 2
//   verifica_status     toggles once per accepted move
//   turno               0 = player 1 to move, 1 = player 2
//   jugada_invalida     one-cycle pulse on a rejected move
//   move_count          accepted moves since clear, 0..9
//   fin_juego           high while in FIN
//   timeout_pulse       (only with TURN_TIMEOUT_EN) turn forfeited pulse
//
// Optional feature macro: TURN_TIMEOUT_EN (turn timer, timeout_pulse port).
module tablero_gato #(
    parameter int unsigned VERIF_WAIT     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic       new_game,
    input  logic       game_over,
    output logic [1:0] reg_c1,
    output logic [1:0] reg_c2,
    output logic [1:0] reg_c3,
    output logic [1:0] reg_c4,
    output logic [1:0] reg_c5,
    output logic [1:0] reg_c6,
    output logic [1:0] reg_c7,
    output logic [1:0] reg_c8,
    output logic [1:0] reg_c9,
    output logic       verifica_status,
    output logic       turno,
    output logic       jugada_invalida,
    output logic [3:0] move_count,
    output logic       fin_juego
`ifdef TURN_TIMEOUT_EN
    ,
    output logic       timeout_pulse
`endif
);

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned CELL_W    = 2;
    localparam int unsigned POS_W     = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned WAIT_W    = $clog2(VERIF_WAIT + 1);

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [CELL_W-1:0] CELL_P1    = 2'b11;
    localparam logic [CELL_W-1:0] CELL_P2    = 2'b01;
    localparam logic [CNT_W-1:0]  MAX_MOVES  = 4'd9;

    // Both timing parameters must be at least one cycle.
    if (VERIF_WAIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tablero_gato: VERIF_WAIT and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        ESCRIBE  = 2'd1,
        VERIFICA = 2'd2,
        FIN      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CELL_W-1:0]  cell_q [NUM_CELLS];
    logic [CELL_W-1:0]  cell_d [NUM_CELLS];
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               turno_q, turno_d;
    logic               vstat_q, vstat_d;
    logic               inval_q, inval_d;
    logic               ready_q, ready_d;
    logic               fin_q, fin_d;
    logic               handshake_c;
    logic               pos_ok_c;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               to_pulse_q, to_pulse_d;
`endif

    // Handshake and legality of the requested cell (range 1..9 and empty).
    always_comb begin
        handshake_c = move_valid && ready_q;
        pos_ok_c    = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (move_pos == POS_W'(i + 1)) begin
                pos_ok_c = (cell_q[i] == CELL_EMPTY);
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        pos_d   = pos_q;
        count_d = count_q;
        wait_d  = wait_q;
        turno_d = turno_q;
        vstat_d = vstat_q;
        inval_d = 1'b0;
`ifdef TURN_TIMEOUT_EN
        to_cnt_d   = '0;
        to_pulse_d = 1'b0;
`endif

        if (new_game) begin
            // Clear wins over any move presented in the same cycle.
            for (int i = 0; i < NUM_CELLS; i++) begin
                cell_d[i] = CELL_EMPTY;
            end
            count_d = '0;
            turno_d = 1'b0;
            wait_d  = '0;
            state_d = ESPERA;
        end else begin
            case (state_q)
                ESPERA: begin
                    if (handshake_c) begin
                        if (pos_ok_c) begin
                            pos_d   = move_pos;
                            state_d = ESCRIBE;
                        end else begin
                            inval_d = 1'b1;
                        end
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        turno_d    = ~turno_q;
                        to_pulse_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`endif
                end

                ESCRIBE: begin
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if (pos_q == POS_W'(i + 1)) begin
                            cell_d[i] = turno_q ? CELL_P2 : CELL_P1;
                        end
                    end
                    if (count_q != MAX_MOVES) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    vstat_d = ~vstat_q;
                    wait_d  = WAIT_W'(VERIF_WAIT);
                    state_d = VERIFICA;
                end

                VERIFICA: begin
                    // Verdict sampled on the edge where the counter reaches 0,
                    // VERIF_WAIT cycles after the verifica_status toggle.
                    if (wait_q <= WAIT_W'(1)) begin
                        wait_d = '0;
                        if (game_over || count_q == MAX_MOVES) begin
                            state_d = FIN;
                        end else begin
                            turno_d = ~turno_q;
                            state_d = ESPERA;
                        end
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end

                FIN: begin
                    state_d = FIN;
                end

                default: begin
                    state_d = ESPERA;
                end
            endcase
        end

        // Status flags registered from the upcoming state.
        ready_d = (state_d == ESPERA);
        fin_d   = (state_d == FIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ESPERA;
            cell_q  <= '{default: CELL_EMPTY};
            pos_q   <= '0;
            count_q <= '0;
            wait_q  <= '0;
            turno_q <= 1'b0;
            vstat_q <= 1'b0;
            inval_q <= 1'b0;
            ready_q <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            pos_q   <= pos_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            turno_q <= turno_d;
            vstat_q <= vstat_d;
            inval_q <= inval_d;
            ready_q <= ready_d;
            fin_q   <= fin_d;
        end
    end

`ifdef TURN_TIMEOUT_EN
    // Turn timer; cleared outside ESPERA, so it restarts on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q   <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            to_pulse_q <= to_pulse_d;
        end
    end

    assign timeout_pulse = to_pulse_q;
`endif

    assign reg_c1          = cell_q[0];
    assign reg_c2          = cell_q[1];
    assign reg_c3          = cell_q[2];
    assign reg_c4          = cell_q[3];
    assign reg_c5          = cell_q[4];
    assign reg_c6          = cell_q[5];
    assign reg_c7          = cell_q[6];
    assign reg_c8          = cell_q[7];
    assign reg_c9          = cell_q[8];
    assign move_ready      = ready_q;
    assign verifica_status = vstat_q;
    assign turno           = turno_q;
    assign jugada_invalida = inval_q;
    assign move_count      = count_q;
    assign fin_juego       = fin_q;

endmodule

// File: tb/tb_tablero_gato.sv
// Directed self-checking bench for tablero_gato (VERIF_WAIT=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tablero_gato;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       new_game;
    logic       game_over;
    logic [1:0] reg_c1, reg_c2, reg_c3, reg_c4, reg_c5;
    logic [1:0] reg_c6, reg_c7, reg_c8, reg_c9;
    logic       verifica_status;
    logic       turno;
    logic       jugada_invalida;
    logic [3:0] move_count;
    logic       fin_juego;
`ifdef TURN_TIMEOUT_EN
    logic       timeout_pulse;
`endif

    int          errors = 0;
    int          checks = 0;
    logic        exp_vs;
    logic [17:0] board;
    logic [17:0] exp_board;

    assign board = {reg_c9, reg_c8, reg_c7, reg_c6, reg_c5,
                    reg_c4, reg_c3, reg_c2, reg_c1};

    tablero_gato #(
        .VERIF_WAIT    (2),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .move_valid     (move_valid),
        .move_pos       (move_pos),
        .move_ready     (move_ready),
        .new_game       (new_game),
        .game_over      (game_over),
        .reg_c1         (reg_c1),
        .reg_c2         (reg_c2),
        .reg_c3         (reg_c3),
        .reg_c4         (reg_c4),
        .reg_c5         (reg_c5),
        .reg_c6         (reg_c6),
        .reg_c7         (reg_c7),
        .reg_c8         (reg_c8),
        .reg_c9         (reg_c9),
        .verifica_status(verifica_status),
        .turno          (turno),
        .jugada_invalida(jugada_invalida),
        .move_count     (move_count),
        .fin_juego      (fin_juego)
`ifdef TURN_TIMEOUT_EN
        ,
        .timeout_pulse  (timeout_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for move_ready, then complete one handshake.
    task automatic do_move(input logic [3:0] p);
        for (int k = 0; k < 20 && move_ready !== 1'b1; k++) step();
        chk("ready_wait", 32'(move_ready), 32'd1);
        move_valid = 1'b1;
        move_pos   = p;
        step();
        move_valid = 1'b0;
        exp_vs     = ~exp_vs;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        new_game   = 1'b0;
        game_over  = 1'b0;
        exp_vs     = 1'b0;

        // Reset values
        #12;
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_turno", 32'(turno), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_vstat", 32'(verifica_status), 32'd0);
        chk("rst_ready", 32'(move_ready), 32'd0);
        chk("rst_inval", 32'(jugada_invalida), 32'd0);
        chk("rst_fin", 32'(fin_juego), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(move_ready), 32'd1);

        // First move: cell 5 by player 1, cycle-exact timing
        move_valid = 1'b1;
        move_pos   = 4'd5;
        step();
        move_valid = 1'b0;
        exp_vs     = ~exp_vs;
        chk("m1_ready_low", 32'(move_ready), 32'd0);
        chk("m1_c5_not_yet", 32'(reg_c5), 32'd0);
        chk("m1_inval", 32'(jugada_invalida), 32'd0);
        step();
        chk("m1_c5", 32'(reg_c5), 32'd3);
        chk("m1_vstat", 32'(verifica_status), 32'd1);
        chk("m1_count", 32'(move_count), 32'd1);
        chk("m1_turno_e1", 32'(turno), 32'd0);
        step();
        chk("m1_turno_e2", 32'(turno), 32'd0);
        chk("m1_ready_e2", 32'(move_ready), 32'd0);
        step();
        chk("m1_turno_e3", 32'(turno), 32'd1);
        chk("m1_ready_e3", 32'(move_ready), 32'd1);

        // Occupied cell rejected
        move_valid = 1'b1;
        move_pos   = 4'd5;
        step();
        move_valid = 1'b0;
        chk("occ_inval", 32'(jugada_invalida), 32'd1);
        chk("occ_c5", 32'(reg_c5), 32'd3);
        chk("occ_ready", 32'(move_ready), 32'd1);
        step();
        chk("occ_inval_end", 32'(jugada_invalida), 32'd0);
        chk("occ_turno", 32'(turno), 32'd1);
        chk("occ_count", 32'(move_count), 32'd1);
        chk("occ_vstat", 32'(verifica_status), 32'd1);

        // Out-of-range positions 0 and 10
        move_valid = 1'b1;
        move_pos   = 4'd0;
        step();
        move_valid = 1'b0;
        chk("pos0_inval", 32'(jugada_invalida), 32'd1);
        chk("pos0_board", 32'(board), 32'h00300);
        step();
        move_valid = 1'b1;
        move_pos   = 4'd10;
        step();
        move_valid = 1'b0;
        chk("pos10_inval", 32'(jugada_invalida), 32'd1);
        chk("pos10_board", 32'(board), 32'h00300);
        step();
        chk("pos10_inval_end", 32'(jugada_invalida), 32'd0);

        // Row win 1,4,2,5,3 then FIN
        pulse_new_game();
        chk("ng1_board", 32'(board), 32'd0);
        chk("ng1_turno", 32'(turno), 32'd0);
        chk("ng1_count", 32'(move_count), 32'd0);
        chk("ng1_vstat", 32'(verifica_status), 32'(exp_vs));
        do_move(4'd1);
        do_move(4'd4);
        do_move(4'd2);
        do_move(4'd5);
        do_move(4'd3);
        game_over = 1'b1;
        step();
        step();
        step();
        chk("win_fin", 32'(fin_juego), 32'd1);
        chk("win_ready", 32'(move_ready), 32'd0);
        chk("win_count", 32'(move_count), 32'd5);
        chk("win_board", 32'(board), 32'h0017F);
        chk("win_turno", 32'(turno), 32'd0);
        chk("win_vstat", 32'(verifica_status), 32'(exp_vs));
        move_valid = 1'b1;
        move_pos   = 4'd9;
        step();
        step();
        chk("fin_c9", 32'(reg_c9), 32'd0);
        chk("fin_count", 32'(move_count), 32'd5);
        chk("fin_hold", 32'(fin_juego), 32'd1);
        chk("fin_inval", 32'(jugada_invalida), 32'd0);
        move_valid = 1'b0;
        game_over  = 1'b0;
        pulse_new_game();
        chk("ng2_board", 32'(board), 32'd0);
        chk("ng2_turno", 32'(turno), 32'd0);
        chk("ng2_count", 32'(move_count), 32'd0);
        chk("ng2_fin", 32'(fin_juego), 32'd0);
        chk("ng2_ready", 32'(move_ready), 32'd1);
        chk("ng2_vstat", 32'(verifica_status), 32'(exp_vs));

        // Move coinciding with new_game is dropped silently
        move_valid = 1'b1;
        move_pos   = 4'd6;
        new_game   = 1'b1;
        step();
        move_valid = 1'b0;
        new_game   = 1'b0;
        chk("sim_inval", 32'(jugada_invalida), 32'd0);
        chk("sim_board", 32'(board), 32'd0);
        chk("sim_ready", 32'(move_ready), 32'd1);
        step();
        chk("sim_board2", 32'(board), 32'd0);
        chk("sim_count", 32'(move_count), 32'd0);

        // Nine legal moves without a verdict: full board ends the game
        for (int p = 1; p <= 9; p++) do_move(4'(p));
        step();
        step();
        step();
        for (int i = 0; i < 9; i++) exp_board[2*i +: 2] = (i % 2 == 0) ? 2'b11 : 2'b01;
        chk("full_count", 32'(move_count), 32'd9);
        chk("full_fin", 32'(fin_juego), 32'd1);
        chk("full_ready", 32'(move_ready), 32'd0);
        chk("full_board", 32'(board), 32'(exp_board));
        chk("full_vstat", 32'(verifica_status), 32'(exp_vs));

        // Asynchronous reset in the middle of VERIFICA
        pulse_new_game();
        do_move(4'd7);
        step();
        chk("mid_c7", 32'(reg_c7), 32'd3);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_board", 32'(board), 32'd0);
        chk("mid_rst_turno", 32'(turno), 32'd0);
        chk("mid_rst_count", 32'(move_count), 32'd0);
        chk("mid_rst_vstat", 32'(verifica_status), 32'd0);
        chk("mid_rst_ready", 32'(move_ready), 32'd0);
        chk("mid_rst_fin", 32'(fin_juego), 32'd0);
        chk("mid_rst_inval", 32'(jugada_invalida), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TURN_TIMEOUT_EN
        // Idle turn forfeits after TIMEOUT_CYCLES=10 cycles in ESPERA
        for (int k = 0; k < 9; k++) step();
        chk("to_pulse_pre", 32'(timeout_pulse), 32'd0);
        chk("to_turno_pre", 32'(turno), 32'd0);
        step();
        chk("to_pulse", 32'(timeout_pulse), 32'd1);
        chk("to_turno", 32'(turno), 32'd1);
        chk("to_board", 32'(board), 32'd0);
        step();
        chk("to_pulse_end", 32'(timeout_pulse), 32'd0);
        chk("to_count", 32'(move_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
